// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Brief    : Instruction bundle carried between pipeline stages: valid bit,
//            register-write control, destination register and packed payload.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 96,
  parameter int REG_AW    = 5
);
  logic                 valid;
  logic                 reg_write;
  logic [REG_AW-1:0]    write_reg;
  logic [PAYLOAD_W-1:0] payload;

  // Producer side of the bundle
  modport master (output valid, reg_write, write_reg, payload);
  // Consumer side of the bundle
  modport slave  (input  valid, reg_write, write_reg, payload);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Parametrised pipeline stage register with stall/flush control,
//            two-operand forwarding match and saturating stall/bubble
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 96,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                clr_cnt_i,
  input  logic [REG_AW-1:0]   src_a_i,
  input  logic [REG_AW-1:0]   src_b_i,
  pipe_stage_reg_if.slave     up_i,
  pipe_stage_reg_if.master    dn_o,
  output logic                fwd_a_o,
  output logic                fwd_b_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [REG_AW-1:0] c_REG_ZERO = {REG_AW{1'b0}};

  logic                 valid_q,      valid_d;
  logic                 reg_write_q,  reg_write_d;
  logic [REG_AW-1:0]    write_reg_q,  write_reg_d;
  logic [PAYLOAD_W-1:0] payload_q,    payload_d;
  logic [CNT_W-1:0]     stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

  logic                 stall_event;
  logic                 bubble_event;

  // A stall only counts when no flush overrides it; a bubble is any edge
  // that leaves an invalid entry in the stage.
  assign stall_event  = stall_i & ~flush_i;
  assign bubble_event = flush_i | (~stall_i & ~up_i.valid);

  // Next stage contents: flush beats stall beats normal load.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    write_reg_d = write_reg_q;
    payload_d   = payload_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      write_reg_d = '0;
      payload_d   = '0;
    end else if (!stall_i) begin
      valid_d     = up_i.valid;
      // A write to $0 or from an invalid slot must never reach the GPR file.
      reg_write_d = up_i.reg_write & up_i.valid & (up_i.write_reg != c_REG_ZERO);
      write_reg_d = up_i.write_reg;
      payload_d   = up_i.payload;
    end
  end

  // Next counter values: clear wins over increment, increments saturate.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_event && (stall_cnt_q != c_CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (bubble_event && (bubble_cnt_q != c_CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end
  end

  // State register; reset overrides stall, flush and clear alike.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      payload_q    <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      payload_q    <= payload_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign dn_o.valid     = valid_q;
  assign dn_o.reg_write = reg_write_q;
  assign dn_o.write_reg = write_reg_q;
  assign dn_o.payload   = payload_q;

  // Source $0 is hard-wired zero and is never forwarded.
  assign fwd_a_o = valid_q & reg_write_q & (write_reg_q == src_a_i) & (src_a_i != c_REG_ZERO);
  assign fwd_b_o = valid_q & reg_write_q & (write_reg_q == src_b_i) & (src_b_i != c_REG_ZERO);

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed self-checking bench for pipe_stage_reg: a full-size
//            stage plus a CNT_W=2 stage for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic clk;
  logic reset;

  // Main stage (default widths)
  logic        stall_i, flush_i, clr_cnt_i;
  logic [4:0]  src_a_i, src_b_i;
  logic        fwd_a_o, fwd_b_o;
  logic [15:0] stall_cnt_o, bubble_cnt_o;

  // Small-counter stage
  logic        s_stall_i, s_flush_i, s_clr_cnt_i;
  logic [4:0]  s_src_a_i, s_src_b_i;
  logic        s_fwd_a_o, s_fwd_b_o;
  logic [1:0]  s_stall_cnt_o, s_bubble_cnt_o;

  int n_cmp;
  int n_err;

  pipe_stage_reg_if #(.PAYLOAD_W(96), .REG_AW(5)) up_if ();
  pipe_stage_reg_if #(.PAYLOAD_W(96), .REG_AW(5)) dn_if ();
  pipe_stage_reg_if #(.PAYLOAD_W(8),  .REG_AW(5)) s_up_if ();
  pipe_stage_reg_if #(.PAYLOAD_W(8),  .REG_AW(5)) s_dn_if ();

  pipe_stage_reg #(.PAYLOAD_W(96), .REG_AW(5), .CNT_W(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .clr_cnt_i    (clr_cnt_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .up_i         (up_if.slave),
    .dn_o         (dn_if.master),
    .fwd_a_o      (fwd_a_o),
    .fwd_b_o      (fwd_b_o),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  pipe_stage_reg #(.PAYLOAD_W(8), .REG_AW(5), .CNT_W(2)) u_dut_small (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (s_stall_i),
    .flush_i      (s_flush_i),
    .clr_cnt_i    (s_clr_cnt_i),
    .src_a_i      (s_src_a_i),
    .src_b_i      (s_src_b_i),
    .up_i         (s_up_if.slave),
    .dn_o         (s_dn_if.master),
    .fwd_a_o      (s_fwd_a_o),
    .fwd_b_o      (s_fwd_b_o),
    .stall_cnt_o  (s_stall_cnt_o),
    .bubble_cnt_o (s_bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic v, input logic rw, input logic [4:0] wr, input logic [95:0] pl);
    up_if.valid     = v;
    up_if.reg_write = rw;
    up_if.write_reg = wr;
    up_if.payload   = pl;
  endtask

  localparam logic [95:0] P1 = 96'h00000001_DEADBEEF_00400004;
  localparam logic [95:0] P2 = 96'h00000002_CAFEF00D_00400008;
  localparam logic [95:0] P3 = 96'h00000003_12345678_0040000C;
  localparam logic [95:0] P4 = 96'h00000004_A5A5A5A5_00400010;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    stall_i = 0; flush_i = 0; clr_cnt_i = 0; src_a_i = 0; src_b_i = 0;
    load(0, 0, 0, '0);
    s_stall_i = 0; s_flush_i = 0; s_clr_cnt_i = 0; s_src_a_i = 0; s_src_b_i = 0;
    s_up_if.valid = 0; s_up_if.reg_write = 0; s_up_if.write_reg = 0; s_up_if.payload = 0;

    // Reset state
    tick(); tick();
    check("rst_valid",  dn_if.valid,     0);
    check("rst_rw",     dn_if.reg_write, 0);
    check("rst_wr",     dn_if.write_reg, 0);
    check("rst_pl",     dn_if.payload,   0);
    check("rst_scnt",   stall_cnt_o,     0);
    check("rst_bcnt",   bubble_cnt_o,    0);

    // Normal load, 1-cycle latency
    reset = 0;
    load(1, 1, 5'd8, P1);
    src_a_i = 5'd8;
    tick();
    check("ld_valid", dn_if.valid,     1);
    check("ld_rw",    dn_if.reg_write, 1);
    check("ld_wr",    dn_if.write_reg, 8);
    check("ld_pl",    dn_if.payload,   P1);
    check("ld_fwda",  fwd_a_o,         1);
    check("ld_bcnt",  bubble_cnt_o,    0);

    // Reset pulse clears everything
    reset = 1;
    tick();
    check("rp_valid", dn_if.valid,     0);
    check("rp_pl",    dn_if.payload,   0);
    check("rp_fwda",  fwd_a_o,         0);
    reset = 0;

    // Write to $0 is never a register write; src 0 never forwards
    load(1, 1, 5'd0, P2);
    src_a_i = 5'd0;
    tick();
    check("r0_valid", dn_if.valid,     1);
    check("r0_rw",    dn_if.reg_write, 0);
    check("r0_pl",    dn_if.payload,   P2);
    check("r0_fwda",  fwd_a_o,         0);

    // Load rd=9, then stall 3 cycles with changing inputs
    load(1, 1, 5'd9, P3);
    src_b_i = 5'd9;
    tick();
    check("rd9_fwdb", fwd_b_o, 1);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      load(i[0], ~i[0], 5'(i + 3), {3{32'($urandom)}});
      tick();
      check("stl_wr",   dn_if.write_reg, 9);
      check("stl_pl",   dn_if.payload,   P3);
      check("stl_fwdb", fwd_b_o,         1);
      check("stl_scnt", stall_cnt_o,     16'(i + 1));
    end
    check("stl_bcnt", bubble_cnt_o, 0);

    // Flush overrides simultaneous stall
    flush_i = 1;
    tick();
    check("fl_valid", dn_if.valid,     0);
    check("fl_rw",    dn_if.reg_write, 0);
    check("fl_wr",    dn_if.write_reg, 0);
    check("fl_pl",    dn_if.payload,   0);
    check("fl_fwdb",  fwd_b_o,         0);
    check("fl_scnt",  stall_cnt_o,     3);
    check("fl_bcnt",  bubble_cnt_o,    1);
    flush_i = 0;
    stall_i = 0;

    // Invalid input: still captured, no register write, counts a bubble
    load(0, 1, 5'd5, P4);
    src_a_i = 5'd5;
    tick();
    check("iv_valid", dn_if.valid,     0);
    check("iv_rw",    dn_if.reg_write, 0);
    check("iv_wr",    dn_if.write_reg, 5);
    check("iv_pl",    dn_if.payload,   P4);
    check("iv_fwda",  fwd_a_o,         0);
    check("iv_bcnt",  bubble_cnt_o,    2);

    // Clear wins over a simultaneous stall increment
    stall_i = 1;
    clr_cnt_i = 1;
    tick();
    check("clr_scnt", stall_cnt_o,     0);
    check("clr_bcnt", bubble_cnt_o,    0);
    check("clr_pl",   dn_if.payload,   P4);
    clr_cnt_i = 0;
    tick();
    check("clr_scnt1", stall_cnt_o, 1);

    // Reset during stall+flush goes fully to reset values
    flush_i = 1;
    load(1, 1, 5'd7, P1);
    tick();
    check("prer_bcnt", bubble_cnt_o, 1);
    reset = 1;
    tick();
    check("rsf_scnt", stall_cnt_o,  0);
    check("rsf_bcnt", bubble_cnt_o, 0);
    check("rsf_valid", dn_if.valid, 0);
    stall_i = 0;
    flush_i = 0;

    // Small counters: saturation at 3 and clear alongside flush
    s_flush_i = 1;
    tick();
    check("s_rst_bcnt", s_bubble_cnt_o, 0);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s_sat_bcnt", s_bubble_cnt_o, (i < 3) ? (i + 1) : 3);
    end
    check("s_sat_scnt", s_stall_cnt_o, 0);
    s_clr_cnt_i = 1;
    tick();
    check("s_clr_bcnt", s_bubble_cnt_o, 0);
    s_clr_cnt_i = 0;
    tick();
    check("s_post_bcnt", s_bubble_cnt_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
